enigma_rotor_stepper: RTL
=========================

# enigma_rotor_stepper

Rotor stepping controller for the Enigma datapath. Accepts one keyed letter at a time over a valid/ready handshake and advances the three rotor positions with odometer carry and the double-step anomaly. It then presents the letter together with the stable, already-stepped positions to the forward/reverse rotor chain. It sits directly upstream of every rotor stage and drives the `position` input of the forward and reverse rotors.

## Interface
- `ALPHA`, default 26: alphabet size; all positions and letters are 0..ALPHA-1 (A=0).
- `NOTCH0`, default 16 (Q): turnover position of the fast rotor 0.
- `NOTCH1`, default 4 (E): turnover position of the middle rotor 1.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `load` in 1: load initial ring positions from `init_pos*`.
- `init_pos0`, `init_pos1`, `init_pos2` in 5 each: start positions for rotors 0 (fast), 1 and 2 (slow).
- `key_valid` in 1: `key_in` holds a keyed letter.
- `key_in` in 5: keyed letter.
- `key_ready` out 1: the block can accept a letter.
- `char_valid` out 1: `char_out` and `pos*` are stable for the rotor chain.
- `char_out` out 5: accepted letter.
- `char_ready` in 1: downstream has consumed the ciphered result.
- `pos0`, `pos1`, `pos2` out 5 each: current rotor positions.
- `key_err` out 1: one-cycle pulse when an out-of-range letter is rejected.

## Operation
- States:
  - IDLE: `key_ready`=1.
  - STEP: positions advance.
  - SETTLE: one cycle for the combinational rotor chain to settle.
  - PRESENT: `char_valid`=1 until `char_ready`.
- IDLE→STEP on `key_valid && key_ready && key_in<ALPHA`. `key_in` is latched into `char_out` on that edge.
- `key_valid` with `key_in>=ALPHA` in IDLE:
  - No latch and no step; state stays IDLE.
  - `key_err`=1 for the next cycle.
- STEP edge: all rotors update simultaneously from their pre-step values.
  - Rotor 0 always steps.
  - Rotor 1 steps if `pos0==NOTCH0` or `pos1==NOTCH1` (the second condition is the double step).
  - Rotor 2 steps if `pos1==NOTCH1`.
  - Each position wraps from ALPHA-1 to 0.
- STEP→SETTLE→PRESENT unconditionally.
- PRESENT→IDLE on an edge with `char_ready`=1. `char_ready` is ignored in all other states.
- `load` has priority over everything in every state. On a `load` edge:
  - `pos*` take `init_pos*`. Inputs ≥ALPHA are loaded as value−ALPHA.
  - Any in-flight letter is discarded and the state goes to IDLE.
  - `char_valid`=0 and `key_ready`=1 on the following cycle.
  - A `key_valid` on the same edge is not accepted.

## Timing
- Reset values:
  - `pos0`=`pos1`=`pos2`=0, `char_out`=0.
  - `char_valid`=0, `key_err`=0, state IDLE.
  - `key_ready`=0 while `rst` is high. It is registered and rises on the first clock edge after release.
- Acceptance edge E0 →
  - `key_ready`=0 after E0.
  - `pos*` new after E1.
  - `char_valid`=1 after E2.
- With `char_ready` held high, the earliest next acceptance is edge E3+1, i.e. 4 cycles per letter.
- `pos*` and `char_out` never change while `char_valid`=1.
- Reset asserted mid-operation clears everything asynchronously. There is no partial step.

## Structure
- Shared package `enigma_pkg` holds:
  - `ALPHA_SIZE`=26 and the letter width (5).
  - Rotor notch constants for rotors I–V (Q, E, V, J, Z).
  - The stepper state encoding.
- Sub-module `rotor_counter`: mod-ALPHA 5-bit position register with `step`, `load`, and load-value reduction. It is instantiated three times.
- Stepping conditions and the FSM live in the top.

## Test plan
- Reset release, then `load` (0,0,0) and key A → `pos`=(1,0,0); `char_valid` 2 cycles after the acceptance edge; `char_out`=0.
- `load` (16,0,0) and one key → `pos`=(17,1,0).
- Double step: `load` (15,3,0) and three keys → (16,3,0), (17,4,0), (18,5,1).
- Wrap: `load` (25,25,25) and one key → (0,25,25). `load` init_pos0=28 → `pos0`=2.
- `key_in`=27 in IDLE → `key_err` pulses for one cycle; `pos` unchanged; `key_ready` stays 1.
- Back-pressure and abort:
  - Hold `char_ready`=0 for 5 cycles → `char_valid`, `char_out` and `pos` stay stable.
  - Assert `load` during PRESENT → `char_valid`=0 next cycle and `pos`=`init_pos`.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared constants and types for the Enigma datapath blocks.
package enigma_pkg;

  localparam int ALPHA_SIZE = 26;
  localparam int LETTER_W   = 5;

  // Turnover (notch) positions of the historical rotors I..V: Q, E, V, J, Z.
  localparam int NOTCH_I   = 16;
  localparam int NOTCH_II  = 4;
  localparam int NOTCH_III = 21;
  localparam int NOTCH_IV  = 9;
  localparam int NOTCH_V   = 25;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STEP    = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_PRESENT = 2'd3
  } step_state_e;

endpackage

// File: rtl/rotor_counter.sv
// Mod-ALPHA rotor position register with step and load.
// A load value of ALPHA or above is folded back into range by one subtraction.
module rotor_counter
  import enigma_pkg::*;
#(
  parameter int ALPHA = ALPHA_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic [LETTER_W-1:0] load_val_i,
  input  logic                step_i,
  output logic [LETTER_W-1:0] pos_o
);

  localparam logic [LETTER_W-1:0] AL   = LETTER_W'(ALPHA);
  localparam logic [LETTER_W-1:0] MAXV = LETTER_W'(ALPHA - 1);

  logic [LETTER_W-1:0] pos_q, pos_d;

  // Next position: load wins over step; step wraps ALPHA-1 -> 0.
  always_comb begin
    pos_d = pos_q;
    if (load_i)
      pos_d = (load_val_i >= AL) ? (load_val_i - AL) : load_val_i;
    else if (step_i)
      pos_d = (pos_q == MAXV) ? '0 : (pos_q + 1'b1);
  end

  // Position register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pos_q <= '0;
    else     pos_q <= pos_d;
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/enigma_rotor_stepper.sv
// Rotor stepping controller: accepts one letter, steps the three rotors with
// odometer carry and the middle-rotor double step, then holds the letter and
// stepped positions stable for the rotor chain until downstream consumes it.
module enigma_rotor_stepper
  import enigma_pkg::*;
#(
  parameter int ALPHA  = ALPHA_SIZE,
  parameter int NOTCH0 = NOTCH_I,
  parameter int NOTCH1 = NOTCH_II
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [LETTER_W-1:0] init_pos0,
  input  logic [LETTER_W-1:0] init_pos1,
  input  logic [LETTER_W-1:0] init_pos2,
  input  logic                key_valid,
  input  logic [LETTER_W-1:0] key_in,
  output logic                key_ready,
  output logic                char_valid,
  output logic [LETTER_W-1:0] char_out,
  input  logic                char_ready,
  output logic [LETTER_W-1:0] pos0,
  output logic [LETTER_W-1:0] pos1,
  output logic [LETTER_W-1:0] pos2,
  output logic                key_err
);

  localparam logic [LETTER_W-1:0] AL = LETTER_W'(ALPHA);
  localparam logic [LETTER_W-1:0] N0 = LETTER_W'(NOTCH0);
  localparam logic [LETTER_W-1:0] N1 = LETTER_W'(NOTCH1);

  step_state_e         state_q;
  logic                key_ready_q;
  logic                char_valid_q;
  logic                key_err_q;
  logic [LETTER_W-1:0] char_q;

  logic [LETTER_W-1:0] p0, p1, p2;
  logic                step0, step1, step2;

  // All three step decisions use the pre-step positions, so the rotors move
  // together on the STEP edge. The pos1==N1 term is the double-step anomaly.
  always_comb begin
    step0 = (state_q == ST_STEP);
    step1 = step0 && ((p0 == N0) || (p1 == N1));
    step2 = step0 && (p1 == N1);
  end

  rotor_counter #(.ALPHA(ALPHA)) u_rot0 (
    .clk(clk), .rst(rst), .load_i(load), .load_val_i(init_pos0),
    .step_i(step0), .pos_o(p0)
  );

  rotor_counter #(.ALPHA(ALPHA)) u_rot1 (
    .clk(clk), .rst(rst), .load_i(load), .load_val_i(init_pos1),
    .step_i(step1), .pos_o(p1)
  );

  rotor_counter #(.ALPHA(ALPHA)) u_rot2 (
    .clk(clk), .rst(rst), .load_i(load), .load_val_i(init_pos2),
    .step_i(step2), .pos_o(p2)
  );

  // Control FSM with registered handshake outputs; load aborts from any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      key_ready_q  <= 1'b0;
      char_valid_q <= 1'b0;
      key_err_q    <= 1'b0;
      char_q       <= '0;
    end else begin
      key_err_q <= 1'b0;
      if (load) begin
        state_q      <= ST_IDLE;
        key_ready_q  <= 1'b1;
        char_valid_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            key_ready_q <= 1'b1;
            if (key_valid && key_ready_q) begin
              if (key_in < AL) begin
                char_q      <= key_in;
                state_q     <= ST_STEP;
                key_ready_q <= 1'b0;
              end else begin
                key_err_q <= 1'b1;
              end
            end
          end
          ST_STEP: state_q <= ST_SETTLE;
          ST_SETTLE: begin
            state_q      <= ST_PRESENT;
            char_valid_q <= 1'b1;
          end
          ST_PRESENT: begin
            if (char_ready) begin
              state_q      <= ST_IDLE;
              char_valid_q <= 1'b0;
              key_ready_q  <= 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign key_ready  = key_ready_q;
  assign char_valid = char_valid_q;
  assign key_err    = key_err_q;
  assign char_out   = char_q;
  assign pos0       = p0;
  assign pos1       = p1;
  assign pos2       = p2;

endmodule
